// File: rtl/gen_for_pkg.sv
// Shared types and mode encodings for the sequential generate-for accumulator.
package gen_for_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ALT     = 2'd0;
    localparam logic [1:0] MODE_ADD     = 2'd1;
    localparam logic [1:0] MODE_SUB     = 2'd2;
    localparam logic [1:0] MODE_ALT_SUB = 2'd3;

endpackage

// File: rtl/gen_for_accum_step.sv
// One accumulation step: acc_next = acc + term, where term is A+B or A-B
// chosen by the latched mode and the parity of the current iteration.
module gen_for_accum_step
    import gen_for_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             odd,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] term_s;

    // Select the per-iteration term; alternating modes flip on odd iterations
    always_comb begin
        sum_s  = a + b;
        diff_s = a - b;
        term_s = sum_s;
        case (mode)
            MODE_ALT: begin
                if (odd) begin
                    term_s = diff_s;
                end else begin
                    term_s = sum_s;
                end
            end
            MODE_ADD: term_s = sum_s;
            MODE_SUB: term_s = diff_s;
            MODE_ALT_SUB: begin
                if (odd) begin
                    term_s = sum_s;
                end else begin
                    term_s = diff_s;
                end
            end
            default: term_s = sum_s;
        endcase
        acc_next = acc + term_s;
    end

endmodule

// File: rtl/gen_for_accum_seq.sv
// Multi-cycle accumulator: seed, COUNT add iterations, subtract BIAS, and
// return the result over a valid/ready handshake with no bubble on back-to-back.
module gen_for_accum_seq
    import gen_for_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT   = 4,
    parameter int INIT    = 1,
    parameter int BIAS    = 17,
    parameter int PERSIST = 0,
    localparam int IW     = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] xout,
    output logic [IW-1:0]    iter
);

    localparam logic [WIDTH-1:0] INIT_W    = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] BIAS_W    = WIDTH'(BIAS);
    localparam logic [IW-1:0]    LAST_ITER = IW'(COUNT - 1);
    localparam logic [IW-1:0]    END_ITER  = IW'(COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [WIDTH-1:0] xout_q, xout_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] acc_next_s;
    logic             in_ready_s;
    logic             accept_s;

    gen_for_accum_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .b        (b_q),
        .mode     (mode_q),
        .odd      (iter_q[0]),
        .acc_next (acc_next_s)
    );

    // Next-state logic: FSM, iteration counter, operand latch and result
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        iter_d      = iter_q;
        xout_d      = xout_q;
        out_valid_d = out_valid_q;
        in_ready_s  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        accept_s    = in_valid & in_ready_s;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                acc_d = acc_next_s;
                if (iter_q == LAST_ITER) begin
                    xout_d      = acc_next_s - BIAS_W;
                    out_valid_d = 1'b1;
                    iter_d      = END_ITER;
                    state_d     = DONE;
                end else begin
                    iter_d = iter_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A DONE-state accept overrides the return to IDLE, giving no bubble
        if (accept_s) begin
            a_d         = a;
            b_d         = b;
            mode_d      = mode;
            acc_d       = (PERSIST != 0) ? acc_q : INIT_W;
            iter_d      = '0;
            out_valid_d = 1'b0;
            state_d     = RUN;
        end else begin
            a_d = a_d;
        end
    end

    // State and datapath registers; reset also aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= INIT_W;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_ALT;
            iter_q      <= '0;
            xout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            iter_q      <= iter_d;
            xout_q      <= xout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign xout      = xout_q;
    assign iter      = iter_q;

endmodule

// File: tb/tb_gen_for_accum_seq.sv
// Directed bench: two instances (PERSIST=0 and PERSIST=1) share one stimulus stream.
module tb_gen_for_accum_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic [1:0] mode_i;
    logic       out_ready_i;

    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic [7:0] xout0, xout1;
    logic [2:0] iter0, iter1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gen_for_accum_seq #(.WIDTH(8), .COUNT(4), .INIT(1), .BIAS(17), .PERSIST(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i), .in_ready(in_ready0),
        .a(a_i), .b(b_i), .mode(mode_i), .out_valid(out_valid0),
        .out_ready(out_ready_i), .xout(xout0), .iter(iter0)
    );

    gen_for_accum_seq #(.WIDTH(8), .COUNT(4), .INIT(1), .BIAS(17), .PERSIST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_i), .in_ready(in_ready1),
        .a(a_i), .b(b_i), .mode(mode_i), .out_valid(out_valid1),
        .out_ready(out_ready_i), .xout(xout1), .iter(iter1)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] x0;
        logic [7:0] x1;
        int         hold;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic start_op(input string name, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        mode_i     = m;
        #1;
        chk({name, " in_ready0"}, in_ready0, 1);
        chk({name, " in_ready1"}, in_ready1, 1);
        @(negedge clk);
    endtask

    // Scramble inputs every cycle while the op runs; n counts edges including the accept edge
    task automatic wait_done(output int n);
        n = 1;
        while (out_valid0 !== 1'b1 && n < 20) begin
            a_i        = 8'($urandom);
            b_i        = 8'($urandom);
            mode_i     = 2'($urandom);
            in_valid_i = 1'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] x0, input logic [7:0] x1, input int hold);
        int n;
        start_op(name, m, a, b);
        wait_done(n);
        chk({name, " latency"}, n, 5);
        chk({name, " out_valid1"}, out_valid1, 1);
        chk({name, " xout0"}, xout0, x0);
        chk({name, " xout1"}, xout1, x1);
        chk({name, " in_ready in DONE"}, in_ready0, 0);
        for (int h = 0; h < hold; h++) begin
            a_i    = 8'($urandom);
            b_i    = 8'($urandom);
            mode_i = 2'($urandom);
            @(negedge clk);
            chk({name, " hold out_valid"}, out_valid0, 1);
            chk({name, " hold xout0"}, xout0, x0);
            chk({name, " hold in_ready"}, in_ready0, 0);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk({name, " out_valid drop"}, out_valid0, 0);
        chk({name, " idle in_ready"}, in_ready0, 1);
        out_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{2'd0, 8'd10,  8'd3,  8'd24,  8'd24, 0};
        vecs[1] = '{2'd1, 8'd255, 8'd255, 8'd232, 8'd16, 0};
        vecs[2] = '{2'd2, 8'd10,  8'd3,  8'd12,  8'd44, 0};
        vecs[3] = '{2'd0, 8'd3,   8'd10, 8'd252, 8'd56, 3};
        vecs[4] = '{2'd3, 8'd10,  8'd3,  8'd24,  8'd96, 0};
        vecs[5] = '{2'd3, 8'd0,   8'd1,  8'd240, 8'd96, 0};
        vecs[6] = '{2'd1, 8'd0,   8'd0,  8'd240, 8'd96, 0};

        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        a_i         = 8'd0;
        b_i         = 8'd0;
        mode_i      = 2'd0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid0, 0);
        chk("reset xout", xout0, 0);
        chk("reset iter", iter0, 0);
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", in_ready0, 1);
        @(negedge clk);

        // Table: PERSIST=1 instance carries acc from one row to the next
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b,
                   vecs[i].x0, vecs[i].x1, vecs[i].hold);
        end

        // Back-to-back: second request accepted on the result handshake edge
        do_reset();
        start_op("b2b first", 2'd0, 8'd10, 8'd3);
        wait_done(n);
        chk("b2b first latency", n, 5);
        chk("b2b first xout0", xout0, 24);
        chk("b2b first xout1", xout1, 24);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        a_i         = 8'd10;
        b_i         = 8'd3;
        mode_i      = 2'd0;
        #1;
        chk("b2b in_ready on handshake", in_ready0, 1);
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("b2b out_valid dropped", out_valid0, 0);
        chk("b2b running in_ready", in_ready0, 0);
        chk("b2b iter restart", iter0, 0);
        wait_done(n);
        chk("b2b second latency", n, 5);
        chk("b2b second xout0", xout0, 24);
        chk("b2b second xout1", xout1, 64);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;

        // Reset during iteration 2 aborts the op and reloads INIT even with PERSIST=1
        start_op("abort", 2'd0, 8'd10, 8'd3);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort iter before reset", iter0, 2);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid0", out_valid0, 0);
        chk("abort out_valid1", out_valid1, 0);
        chk("abort xout", xout0, 0);
        chk("abort iter", iter0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort in_ready after release", in_ready1, 1);
        @(negedge clk);
        run_op("after abort", 2'd0, 8'd10, 8'd3, 8'd24, 8'd24, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
